fifo_share_ctrl: RTL and testbench
==================================

# fifo_share_ctrl

Shares one non-lookahead FIFO (write port: `full`/`wr`/`din`; read port: `empty`/`rd`/`dout`, with `dout` valid the cycle after `rd`) between several producers and one consumer. The write side is a round-robin arbiter that grants one of NUM_REQ valid/ready requesters per cycle into the FIFO write port. The read side is a read sequencer that hides the one-cycle `dout` latency behind a 2-entry output buffer and presents a full-throughput valid/ready stream. It sits directly between the producer/consumer logic and the FIFO instance; the FIFO and this block share `clk` and `rst`.

## Interface
Parameters:
- NUM_REQ, 4, number of write requesters (2..16)
- DATA_WIDTH, 32, data width; must match the FIFO

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester write request
- req_data  input  NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  one-hot or zero; requester i's data is consumed this cycle
- last_grant  output  $clog2(NUM_REQ)  index of the most recently accepted requester
- fifo_full  input  1  FIFO full
- fifo_wr  output  1  FIFO write strobe
- fifo_din  output  DATA_WIDTH  FIFO write data
- fifo_empty  input  1  FIFO empty
- fifo_rd  output  1  FIFO read strobe
- fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rd`
- out_valid  output  1  output buffer holds data
- out_data  output  DATA_WIDTH  head of the output buffer
- out_ready  input  1  consumer accepts `out_data` when it is high together with `out_valid`

## Operation
Write arbiter (combinational grant, registered pointer):
- `ptr` (reset 0) is the highest-priority index.
- grant = first i in ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 with `req_valid[i]` high.
- `fifo_wr` = |`req_valid` & !`fifo_full`.
- `req_ready[grant]` = `fifo_wr`; every other `req_ready` bit is 0.
- `fifo_din` = data of the granted requester.
- On each accepted write: `ptr` <= (grant+1) mod NUM_REQ, and `last_grant` <= grant.
- When `fifo_full` is high, `ptr` and `last_grant` hold.
- Requesters must hold valid/data until they see ready.

Read sequencer:
- State:
  - `pend` (1 bit): `fifo_rd` issued last cycle.
  - `cnt` (0..2): occupancy of the 2-entry in-order buffer.
- `pop` = `out_valid` & `out_ready`.
- `fifo_rd` = !`fifo_empty` & ((`cnt` + `pend` - `pop`) < 2). This guarantees no buffer overflow and sustains one word per cycle.
- When `pend` = 1, `fifo_dout` is written to the buffer tail at the end of that cycle.
- Simultaneous capture and pop is legal: `cnt` is unchanged and order is preserved.
- `out_valid` = (`cnt` != 0); `out_data` = buffer head.
- `fifo_rd` is never asserted while `fifo_empty` is high.

Reset (`rst` high at a clock edge, including mid-transfer):
- `ptr`=0, `last_grant`=0, `pend`=0, `cnt`=0.
- Buffered or in-flight words are discarded.
- All outputs are 0 in the cycle after reset and while `rst` is held.
- While `rst` is high, `fifo_wr`, `fifo_rd` and `req_ready` are forced to 0.

## Timing
- Write: zero latency. Request accepted in cycle t means the FIFO write happens at edge t.
- Read: `fifo_rd` in cycle t → `fifo_dout` valid in t+1 → captured at edge t+1 → `out_valid` in t+2.
- Minimum latency from `fifo_empty` falling to `out_valid` is 2 cycles.
- Steady state with `out_ready`=1 and a non-empty FIFO: one word per cycle, with `cnt`=1 and `pend`=1.
- Backpressure: with `out_ready`=0, at most 2 words are buffered; `fifo_rd` stays 0 while `cnt`+`pend` = 2.
- Fairness: a continuously valid requester is granted within NUM_REQ accepted writes.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `req_valid`=1 and `fifo_empty`=0 → `fifo_wr`=0, `fifo_rd`=0, `req_ready`=0, `out_valid`=0; first cycle after release grants requester 0.
- **Round-robin:** all 4 requesters valid with data 'h10,'h11,'h12,'h13, FIFO never full → writes 'h10,'h11,'h12,'h13,'h10,… on consecutive cycles; `last_grant` goes 0,1,2,3,0.
- **Full stall:** `fifo_full`=1 for 3 cycles while requesters 1 and 3 are valid → `fifo_wr`=0 and `req_ready`=0 for those 3 cycles, `ptr` holds; after release, requester 1 is granted, then requester 3.
- **Read stream:** FIFO holds 'h5A,'hF6,'h09,'hC4 and `out_ready`=1 → `out_valid` rises 2 cycles after the first `fifo_rd`; outputs are 'h5A,'hF6,'h09,'hC4 on consecutive cycles; no `fifo_rd` while `fifo_empty`=1.
- **Backpressure:** same data with `out_ready`=0 → exactly 2 `fifo_rd` pulses, then `cnt`=2; with `out_ready` then random (seeded), the output order is preserved with no loss or duplicate.
- **Reset mid-read:** assert `rst` in the cycle after a `fifo_rd` (`pend`=1, `cnt`=1) → `out_valid`=0 in the next cycle and the in-flight word is not presented.

Source files
------------

// File: rtl/fifo_share_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_share_ctrl : round-robin write arbiter + latency-hiding read sequencer
// Revision 1.0
// ============================================================================
module fifo_share_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [$clog2(NUM_REQ)-1:0]    last_grant,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_empty,
  output logic                          fifo_rd,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready
);

  localparam int            PW       = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [PW:0]   NREQ_EXT = (PW+1)'(NUM_REQ);

  // ---------------------------------------------------------------- write side
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] grant_q;
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;
  logic          found;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (PW+1)'(k);
      if (scan_sum >= NREQ_EXT) scan_sum = scan_sum - NREQ_EXT;
      scan_idx = scan_sum[PW-1:0];
      if (!found && req_valid[scan_idx]) begin
        grant = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign fifo_wr    = !rst && (|req_valid) && !fifo_full;
  assign req_ready  = fifo_wr ? (NUM_REQ'(1) << grant) : '0;
  assign fifo_din   = fifo_wr ? req_data[grant*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign last_grant = rst ? '0 : grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      grant_q <= '0;
    end else if (fifo_wr) begin
      ptr     <= (grant == LAST_IDX) ? '0 : grant + PW'(1);
      grant_q <= grant;
    end
  end

  // ----------------------------------------------------------------- read side
  logic                  pend;
  logic [1:0]            cnt;
  logic [2:0]            fill;
  logic                  pop;
  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;

  assign out_valid = !rst && (cnt != 2'd0);
  assign out_data  = out_valid ? slot0 : '0;
  assign pop       = out_valid && out_ready;

  // Occupancy after this cycle's pop, counting the word already in flight.
  assign fill    = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
  assign fifo_rd = !rst && !fifo_empty && (fill < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      pend <= fifo_rd;
      cnt  <= fill[1:0];
      case ({pend, pop})
        2'b01: slot0 <= slot1;
        2'b10: begin
          if (cnt == 2'd0) slot0 <= fifo_dout;
          else             slot1 <= fifo_dout;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= fifo_dout;
          end else begin
            slot0 <= slot1;
            slot1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_share_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_share_ctrl : self-checking bench with a queue-based FIFO model
// Revision 1.0
// ============================================================================
module tb_fifo_share_ctrl;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic [1:0]    last_grant;
  logic          fifo_full;
  logic          fifo_wr;
  logic [DW-1:0] fifo_din;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_dout;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;

  logic          full_force = 1'b0;
  logic          fifo_full_q;
  logic          fifo_clr = 1'b0;
  logic          ld_en = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          underflow = 1'b0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] ldq[$];
  logic [DW-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  assign fifo_full = full_force | fifo_full_q;

  fifo_share_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .last_grant(last_grant),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  // Non-lookahead FIFO: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
    end else begin
      if (fifo_rd) begin
        if (fq.size() == 0) underflow <= 1'b1;
        else                fifo_dout <= fq.pop_front();
      end
      if (fifo_wr) fq.push_back(fifo_din);
      if (ld_en)   fq.push_back(ld_data);
    end
    fifo_empty  <= (fq.size() == 0);
    fifo_full_q <= (fq.size() >= DEPTH);
  end

  typedef struct {
    logic [N-1:0]  valid;
    logic          full;
    logic [N-1:0]  ready;
    logic [DW-1:0] din;
    logic [1:0]    lg;
  } arb_vec_t;

  arb_vec_t tbl[15];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_clr = 1'b1; req_valid = '0; full_force = 1'b0;
    ld_en = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic load_in_reset();
    rst = 1'b1; fifo_clr = 1'b1; req_valid = '0; out_ready = 1'b0; ld_en = 1'b0;
    cyc();
    fifo_clr = 1'b0;
    foreach (ldq[i]) begin
      ld_en = 1'b1; ld_data = ldq[i];
      cyc();
    end
    ld_en = 1'b0;
    rst = 1'b0;
  endtask

  logic [N-1:0]  rv;
  logic [DW-1:0] rdat[N];
  int            waitc[N];

  initial begin
    int ptr_m, lg_m, best, bd, d, maxwait, rdcnt, rd_empty_err, guard;
    logic          ew;
    logic          exp_rd[7];
    logic          exp_ov[7];
    logic [DW-1:0] exp_od[7];

    tbl[0]  = '{4'hF, 1'b0, 4'h1, 32'h10, 2'd0};
    tbl[1]  = '{4'hF, 1'b0, 4'h2, 32'h11, 2'd1};
    tbl[2]  = '{4'hF, 1'b0, 4'h4, 32'h12, 2'd2};
    tbl[3]  = '{4'hF, 1'b0, 4'h8, 32'h13, 2'd3};
    tbl[4]  = '{4'hF, 1'b0, 4'h1, 32'h10, 2'd0};
    tbl[5]  = '{4'hA, 1'b1, 4'h0, 32'h0,  2'd0};
    tbl[6]  = '{4'hA, 1'b1, 4'h0, 32'h0,  2'd0};
    tbl[7]  = '{4'hA, 1'b1, 4'h0, 32'h0,  2'd0};
    tbl[8]  = '{4'hA, 1'b0, 4'h2, 32'h11, 2'd1};
    tbl[9]  = '{4'h8, 1'b0, 4'h8, 32'h13, 2'd3};
    tbl[10] = '{4'h0, 1'b0, 4'h0, 32'h0,  2'd3};
    tbl[11] = '{4'h6, 1'b0, 4'h2, 32'h11, 2'd1};
    tbl[12] = '{4'h5, 1'b0, 4'h4, 32'h12, 2'd2};
    tbl[13] = '{4'h1, 1'b0, 4'h1, 32'h10, 2'd0};
    tbl[14] = '{4'h8, 1'b0, 4'h8, 32'h13, 2'd3};

    // ---- reset with requesters valid and FIFO non-empty
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(32'h10 + i);
    rst = 1'b1; req_valid = '1;
    cyc();
    ld_en = 1'b1; ld_data = 32'hAA;
    cyc();
    ld_en = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk("rst_fifo_wr",    fifo_wr,    0);
      chk("rst_fifo_rd",    fifo_rd,    0);
      chk("rst_req_ready",  req_ready,  0);
      chk("rst_out_valid",  out_valid,  0);
      chk("rst_last_grant", last_grant, 0);
      chk("rst_fifo_din",   fifo_din,   0);
      chk("rst_out_data",   out_data,   0);
      if (r == 1) fifo_clr = 1'b1;
      cyc();
    end
    fifo_clr = 1'b0;
    rst = 1'b0;

    // ---- table: round robin, full stall, wrap-around
    for (int r = 0; r < 15; r++) begin
      req_valid  = tbl[r].valid;
      full_force = tbl[r].full;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].ready);
      chk($sformatf("tbl%0d_wr", r), fifo_wr, |tbl[r].ready);
      if (|tbl[r].ready) chk($sformatf("tbl%0d_din", r), fifo_din, tbl[r].din);
      cyc();
      chk($sformatf("tbl%0d_last_grant", r), last_grant, tbl[r].lg);
    end

    // ---- random arbitration against a distance-based priority model
    do_reset();
    ptr_m = 0; lg_m = 0; maxwait = 0; rv = '0;
    for (int i = 0; i < N; i++) begin rdat[i] = '0; waitc[i] = 0; end
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && ($urandom % 2 == 0)) begin
          rv[i] = 1'b1; rdat[i] = $urandom; waitc[i] = 0;
        end
        req_data[i*DW +: DW] = rdat[i];
      end
      req_valid  = rv;
      full_force = ($urandom % 4 == 0);
      @(negedge clk);
      best = 0; bd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - ptr_m + N) % N;
        if (rv[i] && d < bd) begin bd = d; best = i; end
      end
      ew = (rv != '0) && !fifo_full;
      chk("rnd_wr", fifo_wr, ew);
      chk("rnd_ready", req_ready, ew ? (N'(1) << best) : '0);
      if (ew) chk("rnd_din", fifo_din, rdat[best]);
      cyc();
      if (ew) begin
        for (int i = 0; i < N; i++) if (rv[i]) waitc[i]++;
        if (waitc[best] > maxwait) maxwait = waitc[best];
        rv[best] = 1'b0;
        ptr_m = (best + 1) % N;
        lg_m  = best;
      end
      chk("rnd_last_grant", last_grant, lg_m);
    end
    chk("fairness_bound", (maxwait <= N), 1);

    // ---- read stream with out_ready high
    ldq = '{32'h5A, 32'hF6, 32'h09, 32'hC4};
    load_in_reset();
    out_ready = 1'b1;
    exp_rd = '{1, 1, 1, 1, 0, 0, 0};
    exp_ov = '{0, 0, 1, 1, 1, 1, 0};
    exp_od = '{32'h0, 32'h0, 32'h5A, 32'hF6, 32'h09, 32'hC4, 32'h0};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("strm%0d_rd", c), fifo_rd, exp_rd[c]);
      chk($sformatf("strm%0d_valid", c), out_valid, exp_ov[c]);
      if (exp_ov[c]) chk($sformatf("strm%0d_data", c), out_data, exp_od[c]);
      cyc();
    end

    // ---- backpressure: two reads then stall, then random drain
    load_in_reset();
    out_ready = 1'b0;
    rdcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fifo_rd) rdcnt++;
      chk($sformatf("bp%0d_valid", c), out_valid, (c >= 2));
      if (c >= 2) chk($sformatf("bp%0d_head", c), out_data, 32'h5A);
      cyc();
    end
    chk("bp_rd_pulses", rdcnt, 2);
    exp_q = '{32'h5A, 32'hF6, 32'h09, 32'hC4};
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      out_ready = ($urandom % 2 == 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("bp_extra", out_data, 'x);
        else                   chk("bp_word", out_data, exp_q.pop_front());
      end
      cyc();
      guard++;
    end
    chk("bp_drained", exp_q.size(), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_no_dup", out_valid, 0);
      cyc();
    end

    // ---- reset while a word is in flight
    ldq = '{32'hA1, 32'hB2};
    load_in_reset();
    out_ready = 1'b0;
    @(negedge clk); chk("mid_rd0", fifo_rd, 1); cyc();
    @(negedge clk); chk("mid_rd1", fifo_rd, 1); cyc();
    rst = 1'b1;
    @(negedge clk); chk("mid_rst_rd", fifo_rd, 0); cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); chk("mid_after_valid", out_valid, 0); cyc();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("mid_no_stale", out_valid, 0); cyc();
    end
    ld_en = 1'b1; ld_data = 32'h77;
    cyc();
    ld_en = 1'b0;
    guard = 0;
    while (!out_valid && guard < 6) begin cyc(); guard++; end
    @(negedge clk);
    chk("mid_fresh_valid", out_valid, 1);
    chk("mid_fresh_word", out_data, 32'h77);
    cyc();

    // ---- random loads and random backpressure against an order queue
    do_reset();
    exp_q.delete();
    rd_empty_err = 0;
    for (int c = 0; c < 300; c++) begin
      ld_en = ($urandom % 2 == 0);
      ld_data = $urandom;
      if (ld_en) exp_q.push_back(ld_data);
      out_ready = ($urandom % 3 != 0);
      @(negedge clk);
      if (fifo_rd && fifo_empty) rd_empty_err++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rr_extra", out_data, 'x);
        else                   chk("rr_word", out_data, exp_q.pop_front());
      end
      cyc();
    end
    ld_en = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      if (fifo_rd && fifo_empty) rd_empty_err++;
      if (out_valid) chk("rr_drain_word", out_data, exp_q.pop_front());
      cyc();
      guard++;
    end
    chk("rr_drained", exp_q.size(), 0);
    chk("rr_rd_while_empty", rd_empty_err, 0);
    chk("fifo_underflow", underflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
